// File: rtl/pe_pkg.sv
// Shared types and sizes for the 8x8 PE array and its buffer-side feeders.
package pe_pkg;

    localparam int unsigned ARRAY_SIZE         = 8;
    localparam int unsigned COMPUTE_DATA_WIDTH = 4;
    localparam int unsigned BUFFER_WORD_SIZE   = 16;
    localparam int unsigned NUM_COMPUTE_LANES  = BUFFER_WORD_SIZE / COMPUTE_DATA_WIDTH;
    localparam int unsigned NUM_ELEMS          = ARRAY_SIZE * ARRAY_SIZE;
    localparam int unsigned WORDS_PER_TILE     = NUM_ELEMS / NUM_COMPUTE_LANES;

    typedef logic signed [COMPUTE_DATA_WIDTH-1:0] elem_t;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StLoad
    } loader_state_t;

endpackage

// File: rtl/pe_word_unpack.sv
// Splits one buffer word into signed compute lanes, lane 0 in the LSBs.
module pe_word_unpack
    import pe_pkg::*;
(
    input  logic [BUFFER_WORD_SIZE-1:0] word_i,
    output elem_t                       lanes_o [NUM_COMPUTE_LANES]
);

    always_comb begin
        for (int l = 0; l < NUM_COMPUTE_LANES; l++) begin
            lanes_o[l] = elem_t'(word_i[l*COMPUTE_DATA_WIDTH +: COMPUTE_DATA_WIDTH]);
        end
    end

endmodule

// File: rtl/pe_tile_loader.sv
// Fetches a weight tile and a data tile from the unified buffer, unpacks them into the
// array input vectors, then runs the load_en/compute handoff to the PE array.
module pe_tile_loader
    import pe_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 10,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned LOAD_CYCLES     = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [ADDR_WIDTH-1:0]       weight_base_i,
    input  logic [ADDR_WIDTH-1:0]       data_base_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    output logic                        rd_req_o,
    input  logic                        rd_ready_i,
    output logic [ADDR_WIDTH-1:0]       rd_addr_o,
    input  logic                        rd_valid_i,
    input  logic [BUFFER_WORD_SIZE-1:0] rd_data_i,
    output elem_t                       weights_in_o [NUM_ELEMS],
    output elem_t                       datas_arr_o  [NUM_ELEMS],
    output logic                        load_en_o,
    output logic                        compute_o
);

    localparam int unsigned TotalReqs = 2 * WORDS_PER_TILE;
    localparam int unsigned CntW      = $clog2(TotalReqs + 1);
    localparam int unsigned OutW      = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned LoadW     = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam int unsigned WordIdxW  = $clog2(WORDS_PER_TILE);
    localparam int unsigned ElemIdxW  = $clog2(NUM_ELEMS);

    loader_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] wbase_q, wbase_d, dbase_q, dbase_d;
    logic [CntW-1:0]       issued_q, issued_d, received_q, received_d;
    logic [OutW-1:0]       outstanding_q, outstanding_d;
    logic [LoadW-1:0]      load_cnt_q, load_cnt_d;
    elem_t                 weights_q [NUM_ELEMS];
    elem_t                 weights_d [NUM_ELEMS];
    elem_t                 datas_q   [NUM_ELEMS];
    elem_t                 datas_d   [NUM_ELEMS];
    logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                  load_en_q, load_en_d, compute_q, compute_d;
    logic                  rd_req_q, rd_req_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

    elem_t                 lanes [NUM_COMPUTE_LANES];
    logic                  hs, accept;
    logic [ElemIdxW-1:0]   elem_idx;

    pe_word_unpack u_unpack (
        .word_i  (rd_data_i),
        .lanes_o (lanes)
    );

    assign hs     = rd_req_q & rd_ready_i;
    // A response with nothing outstanding is stale (e.g. from before a reset) and is dropped.
    assign accept = rd_valid_i & (outstanding_q != '0);

    always_comb begin
        state_d       = state_q;
        wbase_d       = wbase_q;
        dbase_d       = dbase_q;
        issued_d      = issued_q;
        received_d    = received_q;
        outstanding_d = outstanding_q;
        load_cnt_d    = load_cnt_q;
        weights_d     = weights_q;
        datas_d       = datas_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        err_d         = err_q | (rd_valid_i & ~accept);
        load_en_d     = 1'b0;
        compute_d     = compute_q;
        rd_req_d      = 1'b0;
        rd_addr_d     = rd_addr_q;
        elem_idx      = '0;

        if (hs) begin
            issued_d = issued_q + CntW'(1);
        end
        if (hs && !accept) begin
            outstanding_d = outstanding_q + OutW'(1);
        end else if (!hs && accept) begin
            outstanding_d = outstanding_q - OutW'(1);
        end

        if (accept) begin
            received_d = received_q + CntW'(1);
            for (int l = 0; l < NUM_COMPUTE_LANES; l++) begin
                elem_idx = ElemIdxW'(int'(received_q[WordIdxW-1:0]) * NUM_COMPUTE_LANES + l);
                if (received_q < CntW'(WORDS_PER_TILE)) begin
                    weights_d[elem_idx] = lanes[l];
                end else begin
                    datas_d[elem_idx] = lanes[l];
                end
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d    = StFetch;
                    wbase_d    = weight_base_i;
                    dbase_d    = data_base_i;
                    issued_d   = '0;
                    received_d = '0;
                    busy_d     = 1'b1;
                    compute_d  = 1'b0;
                end
            end
            StFetch: begin
                if (received_d == CntW'(TotalReqs)) begin
                    state_d    = StLoad;
                    load_en_d  = 1'b1;
                    load_cnt_d = '0;
                end
            end
            StLoad: begin
                if (load_cnt_q == LoadW'(LOAD_CYCLES - 1)) begin
                    state_d   = StIdle;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    compute_d = 1'b1;
                end else begin
                    load_en_d  = 1'b1;
                    load_cnt_d = load_cnt_q + LoadW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Request state is computed from next-state counters, so a stalled request stays put.
        if (state_d == StFetch && issued_d < CntW'(TotalReqs) &&
            outstanding_d < OutW'(MAX_OUTSTANDING)) begin
            rd_req_d  = 1'b1;
            rd_addr_d = (issued_d < CntW'(WORDS_PER_TILE)) ?
                        wbase_d + ADDR_WIDTH'(issued_d) :
                        dbase_d + ADDR_WIDTH'(issued_d - CntW'(WORDS_PER_TILE));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            wbase_q       <= '0;
            dbase_q       <= '0;
            issued_q      <= '0;
            received_q    <= '0;
            outstanding_q <= '0;
            load_cnt_q    <= '0;
            weights_q     <= '{default: '0};
            datas_q       <= '{default: '0};
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            load_en_q     <= 1'b0;
            compute_q     <= 1'b1;
            rd_req_q      <= 1'b0;
            rd_addr_q     <= '0;
        end else begin
            state_q       <= state_d;
            wbase_q       <= wbase_d;
            dbase_q       <= dbase_d;
            issued_q      <= issued_d;
            received_q    <= received_d;
            outstanding_q <= outstanding_d;
            load_cnt_q    <= load_cnt_d;
            weights_q     <= weights_d;
            datas_q       <= datas_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            load_en_q     <= load_en_d;
            compute_q     <= compute_d;
            rd_req_q      <= rd_req_d;
            rd_addr_q     <= rd_addr_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign rd_req_o     = rd_req_q;
    assign rd_addr_o    = rd_addr_q;
    assign weights_in_o = weights_q;
    assign datas_arr_o  = datas_q;
    assign load_en_o    = load_en_q;
    assign compute_o    = compute_q;

endmodule

// File: tb/tb_pe_tile_loader.sv
// Directed bench for pe_tile_loader: buffer responder with configurable latency and backpressure.
module tb_pe_tile_loader;
    import pe_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, busy, done, err, rd_req, rd_ready, rd_valid, load_en, compute;
    logic [9:0]  wbase, dbase, rd_addr;
    logic [15:0] rd_data;
    elem_t       wts [NUM_ELEMS];
    elem_t       dts [NUM_ELEMS];

    pe_tile_loader dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .weight_base_i (wbase),
        .data_base_i   (dbase),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err),
        .rd_req_o      (rd_req),
        .rd_ready_i    (rd_ready),
        .rd_addr_o     (rd_addr),
        .rd_valid_i    (rd_valid),
        .rd_data_i     (rd_data),
        .weights_in_o  (wts),
        .datas_arr_o   (dts),
        .load_en_o     (load_en),
        .compute_o     (compute)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0]        mem [1024];
    logic signed [3:0]  exp_w [NUM_ELEMS];
    logic signed [3:0]  exp_d [NUM_ELEMS];
    logic [15:0]        pend_data [$];
    int                 pend_due [$];

    int n_req, n_resp, max_os, addr_bad, stall_bad, done_cnt, load_cycles, load_bad;
    int done_cycle, first_load, nbad;
    logic busy1, comp1;

    task automatic fill_pattern(input logic [9:0] base);
        for (int w = 0; w < 16; w++) mem[base + 10'(w)] = w[0] ? 16'h6543 : 16'h210F;
    endtask

    task automatic fill_formula(input logic [9:0] base);
        for (int w = 0; w < 16; w++) mem[base + 10'(w)] = 16'(w * 16'h1357 + int'(base) * 3 + 16'h0A0B);
    endtask

    task automatic fill_exp(input logic [9:0] wb, input logic [9:0] db);
        logic [15:0] ww, dw;
        for (int e = 0; e < NUM_ELEMS; e++) begin
            ww = mem[wb + 10'(e / 4)];
            dw = mem[db + 10'(e / 4)];
            exp_w[e] = ww[(e % 4) * 4 +: 4];
            exp_d[e] = dw[(e % 4) * 4 +: 4];
        end
    endtask

    // Drives one load from start; returns just after a negedge once done plus tail cycles pass.
    task automatic run_tile(input logic [9:0] wb, input logic [9:0] db, input int lat,
                            input int rdy_pct, input int extra_start, input int abort_after,
                            input int tail);
        int cyc, tail_left;
        logic prev_stall;
        logic [9:0] prev_addr, exp_a;
        n_req = 0; n_resp = 0; max_os = 0; addr_bad = 0; stall_bad = 0; done_cnt = 0;
        load_cycles = 0; load_bad = 0; done_cycle = -1; first_load = -1;
        tail_left = -1; prev_stall = 1'b0; prev_addr = '0;
        pend_data.delete(); pend_due.delete();
        wbase = wb; dbase = db; start = 1'b1; rd_valid = 1'b0; rd_ready = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (cyc < 2000) begin
            start = (cyc == extra_start);
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                rd_valid = 1'b1;
                rd_data  = pend_data.pop_front();
                void'(pend_due.pop_front());
                n_resp++;
            end else begin
                rd_valid = 1'b0;
                rd_data  = '0;
            end
            rd_ready = (rdy_pct >= 100) || ($urandom_range(99) < rdy_pct);
            if (prev_stall && (!rd_req || rd_addr !== prev_addr)) stall_bad++;
            if (cyc == 1) begin busy1 = busy; comp1 = compute; end
            if (rd_req && rd_ready) begin
                exp_a = (n_req < 16) ? wb + 10'(n_req) : db + 10'(n_req - 16);
                if (rd_addr !== exp_a) addr_bad++;
                pend_data.push_back(mem[rd_addr]);
                pend_due.push_back(cyc + lat);
                n_req++;
            end
            prev_stall = rd_req && !rd_ready;
            prev_addr  = rd_addr;
            if (n_req - n_resp > max_os) max_os = n_req - n_resp;
            if (load_en) begin
                load_cycles++;
                if (first_load < 0) first_load = cyc;
                if (compute !== 1'b0) load_bad++;
            end
            if (done) begin
                done_cnt++;
                done_cycle = cyc;
                if (compute !== 1'b1 || busy !== 1'b0) load_bad++;
                if (tail_left < 0) tail_left = tail;
            end
            if (abort_after >= 0 && n_resp >= abort_after) break;
            if (tail_left == 0) break;
            if (tail_left > 0) tail_left--;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        nbad = 0;
        for (int i = 0; i < NUM_ELEMS; i++) if (wts[i] !== 4'h0 || dts[i] !== 4'h0) nbad++;
        checks++; if (nbad != 0) begin errors++; $display("FAIL reset_arrays: %0d nonzero, expected 0", nbad); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (rd_req !== 1'b0 || rd_addr !== 10'd0) begin errors++; $display("FAIL reset_rd: got req %b addr %0d expected 0 0", rd_req, rd_addr); end
        checks++; if (load_en !== 1'b0 || compute !== 1'b1) begin errors++; $display("FAIL reset_ctrl: got load_en %b compute %b expected 0 1", load_en, compute); end
    endtask

    task automatic test_basic();
        fill_pattern(10'd0); fill_pattern(10'd100); fill_exp(10'd0, 10'd100);
        run_tile(10'd0, 10'd100, 1, 100, -1, -1, 2);
        checks++; if (wts[0] !== 4'hF || wts[3] !== 4'h2 || wts[7] !== 4'h6) begin errors++; $display("FAIL basic_elems: got %0d %0d %0d expected -1 2 6", wts[0], wts[3], wts[7]); end
        checks++; if (dts[0] !== 4'hF || dts[7] !== 4'h6) begin errors++; $display("FAIL basic_data_elems: got %0d %0d expected -1 6", dts[0], dts[7]); end
        nbad = 0;
        for (int i = 0; i < NUM_ELEMS; i++) if (wts[i] !== exp_w[i] || dts[i] !== exp_d[i]) nbad++;
        checks++; if (nbad != 0) begin errors++; $display("FAIL basic_arrays: %0d mismatches, expected 0", nbad); end
        checks++; if (busy1 !== 1'b1 || comp1 !== 1'b0) begin errors++; $display("FAIL basic_start: got busy %b compute %b expected 1 0", busy1, comp1); end
        checks++; if (load_cycles != 2 || first_load != 34 || load_bad != 0) begin errors++; $display("FAIL basic_load_en: got %0d cycles from %0d bad %0d expected 2 from 34 bad 0", load_cycles, first_load, load_bad); end
        checks++; if (done_cycle != 36 || done_cnt != 1) begin errors++; $display("FAIL basic_done: got cycle %0d count %0d expected 36 1", done_cycle, done_cnt); end
        checks++; if (n_req != 32 || addr_bad != 0) begin errors++; $display("FAIL basic_reqs: got %0d reqs %0d bad addr expected 32 0", n_req, addr_bad); end
    endtask

    task automatic test_backpressure();
        fill_pattern(10'd200); fill_pattern(10'd300); fill_exp(10'd200, 10'd300);
        run_tile(10'd200, 10'd300, 5, 50, -1, -1, 2);
        checks++; if (max_os > 4 || max_os < 1) begin errors++; $display("FAIL bp_outstanding: got max %0d expected 1..4", max_os); end
        checks++; if (stall_bad != 0 || addr_bad != 0) begin errors++; $display("FAIL bp_stall: got %0d unstable %0d bad addr expected 0 0", stall_bad, addr_bad); end
        nbad = 0;
        for (int i = 0; i < NUM_ELEMS; i++) if (wts[i] !== exp_w[i] || dts[i] !== exp_d[i]) nbad++;
        checks++; if (nbad != 0) begin errors++; $display("FAIL bp_arrays: %0d mismatches, expected 0", nbad); end
        checks++; if (done_cnt != 1 || n_req != 32 || load_bad != 0) begin errors++; $display("FAIL bp_done: got done %0d reqs %0d bad %0d expected 1 32 0", done_cnt, n_req, load_bad); end
    endtask

    task automatic test_wrap();
        fill_formula(10'd1020); fill_formula(10'd500); fill_exp(10'd1020, 10'd500);
        run_tile(10'd1020, 10'd500, 2, 100, -1, -1, 2);
        checks++; if (addr_bad != 0 || n_req != 32) begin errors++; $display("FAIL wrap_addr: got %0d bad of %0d expected 0 of 32", addr_bad, n_req); end
        nbad = 0;
        for (int i = 0; i < NUM_ELEMS; i++) if (wts[i] !== exp_w[i] || dts[i] !== exp_d[i]) nbad++;
        checks++; if (nbad != 0) begin errors++; $display("FAIL wrap_arrays: %0d mismatches, expected 0", nbad); end
    endtask

    task automatic test_start_in_fetch();
        fill_pattern(10'd0); fill_pattern(10'd100); fill_exp(10'd0, 10'd100);
        run_tile(10'd0, 10'd100, 1, 100, 5, -1, 4);
        checks++; if (n_req != 32 || done_cnt != 1) begin errors++; $display("FAIL restart_ignored: got %0d reqs %0d done expected 32 1", n_req, done_cnt); end
        checks++; if (done_cycle != 36 || addr_bad != 0) begin errors++; $display("FAIL restart_timing: got done %0d bad %0d expected 36 0", done_cycle, addr_bad); end
    endtask

    task automatic test_reset_mid_fetch();
        fill_formula(10'd40); fill_formula(10'd60);
        run_tile(10'd40, 10'd60, 3, 100, -1, 10, 0);
        @(negedge clk); rst = 1'b1; rd_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
        nbad = 0;
        for (int i = 0; i < NUM_ELEMS; i++) if (wts[i] !== 4'h0 || dts[i] !== 4'h0) nbad++;
        checks++; if (nbad != 0) begin errors++; $display("FAIL midrst_arrays: %0d nonzero expected 0", nbad); end
        checks++; if (busy !== 1'b0 || rd_req !== 1'b0 || compute !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got busy %b req %b compute %b err %b expected 0 0 1 0", busy, rd_req, compute, err); end
        rd_valid = 1'b1; rd_data = 16'h8888;
        @(negedge clk); rd_valid = 1'b0;
        nbad = 0;
        for (int i = 0; i < NUM_ELEMS; i++) if (wts[i] !== 4'h0 || dts[i] !== 4'h0) nbad++;
        checks++; if (err !== 1'b1 || nbad != 0) begin errors++; $display("FAIL midrst_stale: got err %b nonzero %0d expected 1 0", err, nbad); end
        fill_exp(10'd40, 10'd60);
        run_tile(10'd40, 10'd60, 1, 100, -1, -1, 1);
        nbad = 0;
        for (int i = 0; i < NUM_ELEMS; i++) if (wts[i] !== exp_w[i] || dts[i] !== exp_d[i]) nbad++;
        checks++; if (nbad != 0 || done_cnt != 1 || err !== 1'b1) begin errors++; $display("FAIL midrst_reload: got %0d mismatches done %0d err %b expected 0 1 1", nbad, done_cnt, err); end
    endtask

    task automatic test_spurious_and_back_to_back();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL spur_pre: got err %b expected 0", err); end
        rd_valid = 1'b1; rd_data = 16'h7777;
        @(negedge clk); rd_valid = 1'b0;
        nbad = 0;
        for (int i = 0; i < NUM_ELEMS; i++) if (wts[i] !== 4'h0 || dts[i] !== 4'h0) nbad++;
        checks++; if (err !== 1'b1 || nbad != 0 || busy !== 1'b0) begin errors++; $display("FAIL spur_idle: got err %b nonzero %0d busy %b expected 1 0 0", err, nbad, busy); end
        fill_pattern(10'd0); fill_pattern(10'd100);
        run_tile(10'd0, 10'd100, 1, 100, -1, -1, 0);
        fill_formula(10'd600); fill_formula(10'd700); fill_exp(10'd600, 10'd700);
        run_tile(10'd600, 10'd700, 1, 100, -1, -1, 1);
        nbad = 0;
        for (int i = 0; i < NUM_ELEMS; i++) if (wts[i] !== exp_w[i] || dts[i] !== exp_d[i]) nbad++;
        checks++; if (nbad != 0 || done_cnt != 1 || done_cycle != 36) begin errors++; $display("FAIL b2b_second: got %0d mismatches done %0d at %0d expected 0 1 36", nbad, done_cnt, done_cycle); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; wbase = '0; dbase = '0;
        rd_ready = 1'b1; rd_valid = 1'b0; rd_data = '0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_basic();
        test_backpressure();
        test_wrap();
        test_start_in_fetch();
        test_reset_mid_fetch();
        test_spurious_and_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
